// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel window front-end.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FDONE
  } state_t;

  // Counter width for a count range of n; never returns 0 so n=1 still gets a bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-in / window-out bundle between the frame source, the controller and sobel_calc.
interface sobel_window_ctrl_if;
    import sobel_pkg::*;

    logic             start_i;
    logic [PIX_W-1:0] pixel_i;
    logic             pixel_valid_i;
    logic             busy_o;
    logic [PIX_W-1:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
    logic             done_o;
    logic             frame_done_o;

    modport master (
        output start_i, pixel_i, pixel_valid_i,
        input  busy_o, d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o,
        input  done_o, frame_done_o
    );

    modport slave (
        input  start_i, pixel_i, pixel_valid_i,
        output busy_o, d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o,
        output done_o, frame_done_o
    );
endinterface

// File: rtl/sobel_line_buf.sv
// One image line of pixels: asynchronous read, synchronous write at the same address.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto plain RAM; stale lines are never emitted.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Frame sequencer, raster counters and 3x3 window assembly feeding sobel_calc.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    sobel_window_ctrl_if.slave bus
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t           state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [PIX_W-1:0] win [9];
    logic             done, busy, frame_done;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic             accept;

    assign accept = (state == ST_STREAM) && bus.pixel_valid_i;

    // lb1 holds row r-1, lb0 holds row r-2; each accept ages one column by one line.
    sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) lb1 (
        .clk(clk), .we(accept), .addr(col), .wdata(bus.pixel_i), .rdata(lb1_rd)
    );
    sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) lb0 (
        .clk(clk), .we(accept), .addr(col), .wdata(lb1_rd), .rdata(lb0_rd)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else begin
            done       <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state <= ST_STREAM;
                        col   <= '0;
                        row   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (bus.pixel_valid_i) begin
                        win[0] <= win[1];
                        win[1] <= win[2];
                        win[2] <= lb0_rd;
                        win[3] <= win[4];
                        win[4] <= win[5];
                        win[5] <= lb1_rd;
                        win[6] <= win[7];
                        win[7] <= win[8];
                        win[8] <= bus.pixel_i;
                        // Columns 0 and 1 only refill the window after a line wrap.
                        done   <= (row >= RW'(2)) && (col >= CW'(2));
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                state      <= ST_FDONE;
                                frame_done <= 1'b1;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                ST_FDONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.frame_done_o = frame_done;
    assign bus.d0_o = win[0];
    assign bus.d1_o = win[1];
    assign bus.d2_o = win[2];
    assign bus.d3_o = win[3];
    assign bus.d4_o = win[4];
    assign bus.d5_o = win[5];
    assign bus.d6_o = win[6];
    assign bus.d7_o = win[7];
    assign bus.d8_o = win[8];

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Streaming front-end controller for `sobel_calc`. It accepts one raster-order 8-bit grayscale frame, buffers the two previous image lines, and assembles the 3x3 neighbourhood `d0..d8` for each interior pixel. It drives the neighbourhood with a one-cycle `done` strobe, which connects directly to `sobel_calc`'s `d0_i..d8_i` / `done_i`. It also sequences frames (start, busy, end-of-frame) for the surrounding pipeline.

## Interface
- `IMG_W`, 640, pixels per line (≥3)
- `IMG_H`, 480, lines per frame (≥3)
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start_i`  in  1  begin a frame; sampled only in IDLE
- `pixel_i`  in  8  input pixel, raster order
- `pixel_valid_i`  in  1  `pixel_i` valid this cycle; no backpressure
- `busy_o`  out  1  high from the accepted start until the frame is finished
- `d0_o..d8_o`  out  8 each  window: d0..d2 = row r-2, cols c-2..c; d3..d5 = row r-1; d6..d8 = row r
- `done_o`  out  1  one-cycle strobe: `d0_o..d8_o` is a complete window
- `frame_done_o`  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, STREAM, FDONE.
- IDLE
  - `start_i` → STREAM; clear the column and row counters.
  - `pixel_valid_i` is ignored.
- STREAM
  - Each cycle with `pixel_valid_i` = 1 is an accept.
  - Gaps (valid = 0) hold all state; `done_o` = 0 during a gap.
- Per accept at column c, row r:
  - Read `lb1[c]` (row r-1) and `lb0[c]` (row r-2) asynchronously, read-before-write.
  - Write `lb1[c]` ← `pixel_i` and `lb0[c]` ← old `lb1[c]`.
  - Shift the window left by one column: new right column is d2 ← old `lb0[c]`, d5 ← old `lb1[c]`, d8 ← `pixel_i`.
- Counters:
  - c increments; at `IMG_W-1` it wraps to 0 and r increments.
  - Accept at (r = `IMG_H-1`, c = `IMG_W-1`) → FDONE.
- `done_o` is registered at the accept edge: 1 iff r ≥ 2 and c ≥ 2. Windows never straddle a line wrap, because columns 0 and 1 refill the window without a strobe.
- Strobes per frame: exactly (IMG_W-2)·(IMG_H-2).
- FDONE
  - Lasts one cycle: `frame_done_o` = 1, `busy_o` = 1, then → IDLE.
  - `start_i` in FDONE is ignored.
- `start_i` in STREAM is ignored (no restart mid-frame).
- Line-buffer contents are not cleared between frames. Rows 0–1 never produce strobes, so stale data is never emitted.
- Widths:
  - Column counter is `$clog2(IMG_W)` bits; row counter is `$clog2(IMG_H)` bits.
  - Pixels pass through unmodified (no arithmetic).

## Timing
- Reset: state IDLE, counters 0, all `d*_o` = 0, `done_o` = 0, `busy_o` = 0, `frame_done_o` = 0.
- Reset has priority over every other input. Reset mid-frame aborts immediately with no `frame_done_o`.
- `busy_o` rises the cycle after `start_i` is sampled in IDLE. It falls the cycle after FDONE.
- Latency: the window and `done_o` are valid in the cycle after the accept of its d8 pixel.
- The last window's `done_o` coincides with the FDONE cycle (`frame_done_o` = 1 in the same cycle).
- Throughput: one window per clock at 100% valid.
- `d*_o` holds its value between strobes; downstream must sample only on `done_o`.

## Structure
- `sobel_pkg` holds:
  - the state enum (IDLE / STREAM / FDONE);
  - `PIX_W` = 8;
  - a helper function for counter widths.
- Sub-module `sobel_line_buf`:
  - one depth-`IMG_W` × 8 memory with async read and sync write;
  - instantiated twice (`lb0`, `lb1`).
- Top level holds the FSM, the counters, and the 3x3 window register array.

## Test plan
Scenarios 1–5 use `IMG_W` = 4, `IMG_H` = 3. Scenario 6 uses the default parameters.
1. `start_i`, then pixels 1..12 at continuous valid → exactly two `done_o` strobes:
   - first: d0..d8 = 1,2,3,5,6,7,9,10,11;
   - second: 2,3,4,6,7,8,10,11,12;
   - `frame_done_o` pulses with the second strobe; `busy_o` drops the next cycle.
2. Same stream with valid deasserted every other cycle → same two windows and values; no `done_o` during gaps.
3. Pixels with valid while in IDLE, then `start_i` and 1..12 → output identical to scenario 1. An extra `start_i` pulse mid-frame changes nothing.
4. Assert `rst` after pixel 7 → next cycle all outputs 0 and state IDLE. A fresh start plus 1..12 reproduces scenario 1 with no `frame_done_o` from the aborted frame.
5. Two back-to-back frames (second frame pixels 101..112) → the second frame's first window is 101,102,103,105,106,107,109,110,111, with no stale first-frame data.
6. Default parameters, random pixels → 638·478 strobes, each window matching a reference model, and exactly one `frame_done_o`.
